// File: rtl/device_axi_lite_bridge_pkg.sv
// Shared definitions for the Aquila device-port to AXI4-Lite bridge:
// response codes, FSM state encoding and the default watchdog limit.
package device_axi_lite_bridge_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    localparam logic [2:0] ST_IDLE_ENC      = 3'd0;
    localparam logic [2:0] ST_WRITE_ENC     = 3'd1;
    localparam logic [2:0] ST_WR_RESP_ENC   = 3'd2;
    localparam logic [2:0] ST_READ_ADDR_ENC = 3'd3;
    localparam logic [2:0] ST_RD_DATA_ENC   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = ST_IDLE_ENC,
        ST_WRITE     = ST_WRITE_ENC,
        ST_WR_RESP   = ST_WR_RESP_ENC,
        ST_READ_ADDR = ST_READ_ADDR_ENC,
        ST_RD_DATA   = ST_RD_DATA_ENC
    } state_e;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/device_axi_lite_bridge.sv
// Single-outstanding bridge from the Aquila uncached device port to an
// AXI4-Lite master, with a watchdog that force-completes stalled transfers.
//
// state        | meaning
// ST_IDLE      | waiting for dev_strobe; bready/rready held high to drain late responses
// ST_WRITE     | AW and W offered; each drops after its own handshake
// ST_WR_RESP   | bready high, waiting for the B response
// ST_READ_ADDR | arvalid high, waiting for arready
// ST_RD_DATA   | rready high, waiting for the R response
module device_axi_lite_bridge
    import device_axi_lite_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dev_strobe,
    input  logic [ADDR_WIDTH-1:0]   dev_addr,
    input  logic                    dev_rw,
    input  logic [DATA_WIDTH/8-1:0] dev_byte_enable,
    input  logic [DATA_WIDTH-1:0]   dev_wdata,
    output logic                    dev_ready,
    output logic [DATA_WIDTH-1:0]   dev_rdata,
    output logic                    bus_err,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W = WDOG_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WDOG_EN ? TIMEOUT_CYCLES - 1 : 0);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       strb_q, strb_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    arvalid_q, arvalid_d;
    logic                    bready_q, bready_d;
    logic                    rready_q, rready_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    dev_ready_q, dev_ready_d;
    logic                    bus_err_q, bus_err_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    aw_hs, w_hs;

    assign aw_hs = awvalid_q && m_axi_awready;
    assign w_hs  = wvalid_q && m_axi_wready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        rdata_d     = rdata_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        dev_ready_d = 1'b0;
        bus_err_d   = 1'b0;
        cnt_d       = cnt_q;

        if (state_q != ST_IDLE) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                bready_d = 1'b1;
                rready_d = 1'b1;
                if (dev_strobe) begin
                    addr_d   = dev_addr;
                    wdata_d  = dev_wdata;
                    strb_d   = dev_byte_enable;
                    rdata_d  = '0;
                    cnt_d    = '0;
                    bready_d = 1'b0;
                    rready_d = 1'b0;
                    if (dev_rw) begin
                        state_d   = ST_WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = ST_READ_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d  = ST_WR_RESP;
                    bready_d = 1'b1;
                end
            end
            ST_WR_RESP: begin
                if (m_axi_bvalid) begin
                    state_d     = ST_IDLE;
                    rready_d    = 1'b1;
                    dev_ready_d = 1'b1;
                    bus_err_d   = resp_is_err(m_axi_bresp);
                end
            end
            ST_READ_ADDR: begin
                if (m_axi_arready) begin
                    state_d   = ST_RD_DATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            ST_RD_DATA: begin
                if (m_axi_rvalid) begin
                    state_d     = ST_IDLE;
                    rdata_d     = m_axi_rdata;
                    bready_d    = 1'b1;
                    dev_ready_d = 1'b1;
                    bus_err_d   = resp_is_err(m_axi_rresp);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A normal completion in the final allowed cycle wins over the watchdog.
        if (WDOG_EN && state_q != ST_IDLE && state_d != ST_IDLE && cnt_q == CNT_LAST) begin
            state_d     = ST_IDLE;
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            arvalid_d   = 1'b0;
            bready_d    = 1'b1;
            rready_d    = 1'b1;
            rdata_d     = '0;
            dev_ready_d = 1'b1;
            bus_err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            rdata_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b1;
            rready_q    <= 1'b1;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            dev_ready_q <= 1'b0;
            bus_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            rdata_q     <= rdata_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            dev_ready_q <= dev_ready_d;
            bus_err_q   <= bus_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign dev_ready     = dev_ready_q;
    assign dev_rdata     = rdata_q;
    assign bus_err       = bus_err_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = strb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_device_axi_lite_bridge.sv
// Directed bench for device_axi_lite_bridge: a table of transactions against
// a delay-programmable AXI slave, plus reset-abort and late-response drain.
module tb_device_axi_lite_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        dev_strobe;
    logic [31:0] dev_addr;
    logic        dev_rw;
    logic [3:0]  dev_byte_enable;
    logic [31:0] dev_wdata;
    logic        dev_ready;
    logic [31:0] dev_rdata;
    logic        bus_err;
    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    device_axi_lite_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .dev_strobe(dev_strobe), .dev_addr(dev_addr), .dev_rw(dev_rw),
        .dev_byte_enable(dev_byte_enable), .dev_wdata(dev_wdata),
        .dev_ready(dev_ready), .dev_rdata(dev_rdata), .bus_err(bus_err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          aw_dly;
        int          w_dly;
        int          b_dly;
        int          ar_dly;
        int          r_dly;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        tmo;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NEVER = 99;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic slave_idle();
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        int  k = 1;
        int  aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
        int  aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
        int  viol = 0;
        bit  b_phase = 0, r_phase = 0, done = 0;
        bit  aw_prev = 0, w_prev = 0, ar_prev = 0;
        bit  aw_hit, w_hit, ar_hit;
        @(negedge clk);
        dev_strobe      = 1'b1;
        dev_rw          = v.rw;
        dev_addr        = v.addr;
        dev_wdata       = v.wdata;
        dev_byte_enable = v.be;
        @(negedge clk);
        dev_strobe = 1'b0;
        while (!done && k <= 40) begin
            if (dev_ready) begin
                done = 1;
            end else begin
                if (aw_prev && !m_axi_awvalid) viol++;
                if (w_prev && !m_axi_wvalid) viol++;
                if (ar_prev && !m_axi_arvalid) viol++;
                if (aw_hs > 0 && m_axi_awvalid) viol++;
                if (w_hs > 0 && m_axi_wvalid) viol++;
                if (ar_hs > 0 && m_axi_arvalid) viol++;

                m_axi_awready = m_axi_awvalid && aw_hs == 0 && aw_cnt >= v.aw_dly;
                m_axi_wready  = m_axi_wvalid && w_hs == 0 && w_cnt >= v.w_dly;
                m_axi_arready = m_axi_arvalid && ar_hs == 0 && ar_cnt >= v.ar_dly;
                if (m_axi_awvalid) aw_cnt++;
                if (m_axi_wvalid) w_cnt++;
                if (m_axi_arvalid) ar_cnt++;

                m_axi_bvalid = 1'b0;
                if (b_phase && b_hs == 0 && b_cnt >= v.b_dly) begin
                    m_axi_bvalid = 1'b1;
                    m_axi_bresp  = v.resp;
                    if (m_axi_bready) b_hs++;
                end
                if (b_phase) b_cnt++;

                m_axi_rvalid = 1'b0;
                if (r_phase && r_hs == 0 && r_cnt >= v.r_dly) begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = v.rdata;
                    m_axi_rresp  = v.resp;
                    if (m_axi_rready) r_hs++;
                end
                if (r_phase) r_cnt++;

                aw_hit = m_axi_awvalid && m_axi_awready;
                w_hit  = m_axi_wvalid && m_axi_wready;
                ar_hit = m_axi_arvalid && m_axi_arready;
                if (aw_hit) begin
                    aw_hs++;
                    chk({tag, " awaddr"}, 64'(m_axi_awaddr), 64'(v.addr));
                    chk({tag, " awprot"}, 64'(m_axi_awprot), 64'(0));
                end
                if (w_hit) begin
                    w_hs++;
                    chk({tag, " wdata"}, 64'(m_axi_wdata), 64'(v.wdata));
                    chk({tag, " wstrb"}, 64'(m_axi_wstrb), 64'(v.be));
                end
                if (ar_hit) begin
                    ar_hs++;
                    chk({tag, " araddr"}, 64'(m_axi_araddr), 64'(v.addr));
                    chk({tag, " arprot"}, 64'(m_axi_arprot), 64'(0));
                end
                aw_prev = m_axi_awvalid && !aw_hit;
                w_prev  = m_axi_wvalid && !w_hit;
                ar_prev = m_axi_arvalid && !ar_hit;
                if (!b_phase && aw_hs > 0 && w_hs > 0) b_phase = 1;
                if (!r_phase && ar_hs > 0) r_phase = 1;
                k++;
                @(negedge clk);
            end
        end
        slave_idle();
        chk({tag, " completed"}, 64'(done), 64'(1));
        chk({tag, " latency"}, 64'(k), 64'(v.exp_lat));
        chk({tag, " bus_err"}, 64'(bus_err), 64'(v.exp_err));
        chk({tag, " valids_at_done"},
            64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 64'(0));
        chk({tag, " protocol_viol"}, 64'(viol), 64'(0));
        if (!v.rw || v.tmo) chk({tag, " dev_rdata"}, 64'(dev_rdata), 64'(v.exp_rdata));
        if (v.rw) begin
            chk({tag, " aw_hs"}, 64'(aw_hs), 64'(v.aw_dly < 50));
            chk({tag, " w_hs"}, 64'(w_hs), 64'(v.w_dly < 50));
            chk({tag, " b_hs"}, 64'(b_hs), 64'(!v.tmo));
        end else begin
            chk({tag, " ar_hs"}, 64'(ar_hs), 64'(v.ar_dly < 50));
            chk({tag, " r_hs"}, 64'(r_hs), 64'(!v.tmo));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk({tag, " no_extra_ready"}, 64'({dev_ready, bus_err}), 64'(0));
            if (!v.rw) chk({tag, " rdata_hold"}, 64'(dev_rdata), 64'(v.exp_rdata));
        end
    endtask

    vec_t vecs[9];
    vec_t wr_min;

    initial begin
        //          rw    addr          wdata         be       aw w  b      ar     r  rdata         resp   tmo lat err rdata
        vecs[0] = '{1'b1, 32'hC000_0004, 32'hA5A5_1234, 4'b1111, 0, 0, 1,     0,     0, 32'h0,        2'b00, 0, 4,  0, 32'h0};
        vecs[1] = '{1'b0, 32'hC000_0010, 32'h0,         4'b0000, 0, 0, 0,     3,     2, 32'h0000_00FF, 2'b00, 0, 8,  0, 32'h0000_00FF};
        vecs[2] = '{1'b1, 32'hC000_0100, 32'h1122_3344, 4'b1100, 5, 0, 1,     0,     0, 32'h0,        2'b00, 0, 9,  0, 32'h0};
        vecs[3] = '{1'b0, 32'hC000_0200, 32'h0,         4'b0000, 0, 0, 0,     0,     0, 32'hDEAD_BEEF, 2'b10, 0, 3,  1, 32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 32'hC000_0300, 32'h0,         4'b0000, 0, 0, 0,     NEVER, 0, 32'h0,        2'b00, 1, 17, 1, 32'h0};
        vecs[5] = '{1'b0, 32'hC000_0304, 32'h0,         4'b0000, 0, 0, 0,     1,     1, 32'h1234_5678, 2'b00, 0, 5,  0, 32'h1234_5678};
        vecs[6] = '{1'b1, 32'hC000_0400, 32'hCAFE_0001, 4'b0101, 0, 3, 0,     0,     0, 32'h0,        2'b11, 0, 6,  1, 32'h0};
        vecs[7] = '{1'b1, 32'hCFFF_FFFC, 32'h0BAD_F00D, 4'b0010, 2, 2, 2,     0,     0, 32'h0,        2'b10, 0, 7,  1, 32'h0};
        vecs[8] = '{1'b1, 32'hC000_0500, 32'h5555_AAAA, 4'b1111, 0, 0, NEVER, 0,     0, 32'h0,        2'b00, 1, 17, 1, 32'h0};
        wr_min  = '{1'b1, 32'hC000_0008, 32'h0F0F_F0F0, 4'b1001, 0, 0, 1,     0,     0, 32'h0,        2'b00, 0, 4,  0, 32'h0};

        rst = 1'b1;
        dev_strobe = 1'b0;
        dev_addr = '0;
        dev_rw = 1'b0;
        dev_byte_enable = '0;
        dev_wdata = '0;
        slave_idle();
        repeat (3) @(negedge clk);
        chk("reset valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 64'(0));
        chk("reset readies", 64'({m_axi_bready, m_axi_rready}), 64'(2'b11));
        chk("reset dev outputs", 64'({dev_ready, bus_err, dev_rdata}), 64'(0));
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            do_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Late responses in IDLE are swallowed without a completion.
        @(negedge clk);
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = 2'b10;
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = 32'h0000_0BAD;
        m_axi_rresp  = 2'b11;
        chk("drain readies", 64'({m_axi_bready, m_axi_rready}), 64'(2'b11));
        @(negedge clk);
        slave_idle();
        chk("drain no ready", 64'({dev_ready, bus_err}), 64'(0));
        @(negedge clk);
        chk("drain no ready2", 64'({dev_ready, bus_err}), 64'(0));

        // Reset while a read address is stalled.
        @(negedge clk);
        dev_strobe = 1'b1;
        dev_rw     = 1'b0;
        dev_addr   = 32'hC000_0600;
        @(negedge clk);
        dev_strobe = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_abort arvalid before", 64'(m_axi_arvalid), 64'(1));
        #2 rst = 1'b1;
        #1;
        chk("rst_abort valids async", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 64'(0));
        chk("rst_abort readies async", 64'({m_axi_bready, m_axi_rready}), 64'(2'b11));
        chk("rst_abort dev outputs", 64'({dev_ready, bus_err, dev_rdata}), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_abort no ready after", 64'({dev_ready, m_axi_arvalid}), 64'(0));
        do_txn(wr_min, "post_rst_write");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/device_axi_lite_bridge.md
# device_axi_lite_bridge

Converts the Aquila uncached device port (strobe/addr/rw/byte-enable request, data-ready completion) into single AXI4-Lite master transactions toward the peripheral interconnect. Sits directly downstream of the Aquila IP's M_DEVICE master port, which covers the 0xC000_0000–0xCFFF_FFFF window. One transaction is outstanding at a time. A watchdog guarantees the core never hangs on an unresponsive slave.

## Interface
- ADDR_WIDTH, 32, address width on both sides
- DATA_WIDTH, 32, data width on both sides; strobe width is DATA_WIDTH/8
- TIMEOUT_CYCLES, 1024, cycles allowed per transaction before forced completion; 0 disables the watchdog
- clk  in  1  system clock; every flop is on the rising edge
- rst  in  1  reset, asynchronous and active-high
- dev_strobe  in  1  one-cycle request pulse
- dev_addr  in  ADDR_WIDTH  request address, held stable until dev_ready
- dev_rw  in  1  1 = write, 0 = read
- dev_byte_enable  in  DATA_WIDTH/8  write byte lanes
- dev_wdata  in  DATA_WIDTH  write data
- dev_ready  out  1  one-cycle completion pulse
- dev_rdata  out  DATA_WIDTH  read data, valid with dev_ready and held until the next accepted strobe
- bus_err  out  1  one-cycle pulse coincident with dev_ready when the response is not OKAY or the watchdog expired
- m_axi_aw{addr,prot,valid} out, m_axi_awready in
- m_axi_w{data,strb,valid} out, m_axi_wready in
- m_axi_b{resp,valid} in, m_axi_bready out
- m_axi_ar{addr,prot,valid} out, m_axi_arready in
- m_axi_r{data,resp,valid} in, m_axi_rready out

## Operation
- States: IDLE, WRITE (AW and W channels open), WR_RESP, READ_ADDR, RD_DATA.
- In IDLE, dev_strobe is accepted.
  - Address, wdata and byte_enable are registered.
  - rw=1 goes to WRITE; rw=0 goes to READ_ADDR.
- dev_strobe outside IDLE is ignored (protocol violation, no queuing).
- WRITE:
  - awvalid and wvalid rise together.
  - Each drops independently after its own handshake, tracked by the aw_done and w_done flags.
  - When both are done, go to WR_RESP.
  - AW and W may complete in the same cycle or in either order.
- WR_RESP: bready=1. On bvalid, complete with bus_err = (bresp != 2'b00).
- READ_ADDR: arvalid=1. On arready, go to RD_DATA.
- RD_DATA: rready=1.
  - On rvalid, latch rdata and complete with bus_err = (rresp != 2'b00).
  - rdata is latched even on error.
- Complete means: pulse dev_ready (and bus_err if applicable), then return to IDLE.
- awprot and arprot are constant 3'b000.
- Valid signals are never dropped before their handshake, except on watchdog expiry.
- Watchdog:
  - The counter clears on strobe acceptance and increments in every non-IDLE cycle.
  - When it reaches TIMEOUT_CYCLES, all valid and ready signals drop and the state goes to IDLE.
  - dev_ready and bus_err pulse, and dev_rdata = 0.
  - A late AXI response arriving afterwards in IDLE is consumed silently: bready and rready are held high in IDLE to drain it.
- Reset, asserted at any time including mid-transaction:
  - State = IDLE.
  - All AXI valid and ready outputs are 0, except bready and rready, which go to 1 (the drain behaviour).
  - dev_ready = 0, bus_err = 0, dev_rdata = 0, counter = 0.

## Timing
- All outputs are registered; there is no combinational path from AXI inputs to dev_* outputs.
- Request accepted at cycle T: awvalid/wvalid or arvalid are high at T+1.
- Minimum write latency, with awready=wready=1 and bvalid returned the cycle after bready:
  - dev_ready at T+4 (AW/W handshake at T+1, WR_RESP at T+2, B handshake at T+3, pulse at T+4).
- Minimum read latency: arready at T+1, rvalid at T+2, dev_ready at T+3.
- Earliest next strobe: the cycle after dev_ready.
- Watchdog pulse is at cycle T+TIMEOUT_CYCLES+1.

## Structure
- A shared package or header holds:
  - AXI response codes: OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
  - The state encoding localparams.
  - The default TIMEOUT_CYCLES.
- A single flat module is sufficient; there is no sub-module.
- The watchdog is an inline $clog2(TIMEOUT_CYCLES+1)-bit counter.

## Test plan
- Write 0xC000_0004, data 0xA5A5_1234, be 4'b1111, slave always ready:
  - awaddr/wdata/wstrb match.
  - dev_ready at T+4, bus_err=0.
- Read 0xC000_0010, slave returns rdata 0x0000_00FF OKAY after 3 wait cycles on arready and 2 on rvalid:
  - dev_rdata=0x0000_00FF with the dev_ready pulse.
  - dev_rdata holds that value afterwards.
- Write where wready precedes awready by 5 cycles:
  - wvalid drops after its handshake and awvalid stays high.
  - Exactly one B handshake occurs, followed by one dev_ready.
- Read with rresp=2'b10:
  - dev_ready and bus_err pulse together.
  - dev_rdata equals the returned data.
- TIMEOUT_CYCLES=16, arready never asserted:
  - At T+17: arvalid=0, dev_ready=1, bus_err=1, dev_rdata=0.
  - A subsequent read to a responsive slave completes normally.
- rst asserted while arvalid=1 is stalled:
  - All valids drop asynchronously and no dev_ready is generated.
  - After release, a write completes with dev_ready at T+4.
